mux8_sel_sequencer: RTL and testbench

- Upstream feeder for the 8:1 select mux. Loads one byte through a valid/ready handshake, holds it on the mux data inputs, and steps the 3-bit select through all eight positions so the mux output becomes a serial bit stream.
- Each bit is held for a programmable number of clock cycles.
- Emits per-bit sample strobes and a frame-last flag for the downstream consumer of the mux output.

---
 rtl/mux8_sel_sequencer_pkg.sv | 23 ++
 rtl/mux8_sel_sequencer_div.sv | 36 +++
 rtl/mux8_sel_sequencer.sv | 83 ++++++++
 tb/tb_mux8_sel_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux8_sel_sequencer_pkg.sv
// Shared types and constants for the 8:1 mux select sequencer.
// Select start/step helpers let the top level stay agnostic of bit order.
package mux8_sel_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                  input bit msb_first);
        return msb_first ? (sel - 3'd1) : (sel + 3'd1);
    endfunction

endpackage

// File: rtl/mux8_sel_sequencer_div.sv
// Bit-period divider: counts DIV cycles while enabled and flags the final one.
// The terminal count is decoded from the registered count only.
module bit_period_div
    import mux8_sel_sequencer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tc = en && (div_cnt == TC_VAL);

    // Clear wins over enable so a freshly loaded frame always starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == TC_VAL) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_sel_sequencer.sv
// Loads a byte via valid/ready and steps the 8:1 mux select through all
// eight positions, one bit period each, emitting sample strobes and last.
module mux8_sel_sequencer
    import mux8_sel_sequencer_pkg::*;
#(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] it,
    output logic [SEL_W-1:0]  sl,
    output logic              bit_strobe,
    output logic              last,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);

    state_t     state;
    logic [2:0] bit_cnt;
    logic       period_tc;
    logic       transfer;

    bit_period_div #(
        .DIV (DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (state == SHIFT),
        .clr (state == IDLE),
        .tc  (period_tc)
    );

    // All handshake and strobe outputs come from registered state only.
    assign busy       = (state == SHIFT);
    assign bit_strobe = busy && period_tc;
    assign last       = bit_strobe && (bit_cnt == 3'd7);
    assign in_ready   = (state == IDLE) || last;
    assign transfer   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            it      <= '0;
            sl      <= SEL_START;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        it      <= in_data;
                        sl      <= SEL_START;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        // Final bit: chain straight into the next byte if offered.
                        sl      <= SEL_START;
                        bit_cnt <= '0;
                        if (transfer) begin
                            it <= in_data;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bit_strobe) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sl      <= sel_step(sl, MSB_FIRST);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_sel_sequencer.sv
// Bench for mux8_sel_sequencer: one LSB-first DIV=1 instance and one
// MSB-first DIV=3 instance, each feeding a behavioural 8:1 mux.
module tb_mux8_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_data = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready, a_strobe, a_last, a_busy, a_ot;
    logic [7:0] a_it;
    logic [2:0] a_sl;

    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_strobe, b_last, b_busy, b_ot;
    logic [7:0] b_it;
    logic [2:0] b_sl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_sel_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .it(a_it), .sl(a_sl), .bit_strobe(a_strobe),
        .last(a_last), .busy(a_busy)
    );

    mux8_sel_sequencer #(.DIV(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .it(b_it), .sl(b_sl), .bit_strobe(b_strobe),
        .last(b_last), .busy(b_busy)
    );

    // Downstream 8:1 mux attached to each sequencer.
    assign a_ot = a_it[a_sl];
    assign b_ot = b_it[b_sl];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       busy;
        logic [2:0] sl;
        logic       ot;
        logic       strb;
        logic       lst;
        logic [7:0] it;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                                input logic busy, input logic [2:0] sl, input logic ot,
                                input logic strb, input logic lst, input logic [7:0] it);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.busy = busy; r.sl = sl;
        r.ot = ot; r.strb = strb; r.lst = lst; r.it = it;
        return r;
    endfunction

    // Drive both instances' inputs after the falling edge, then settle.
    task automatic applyStimulus(input logic av, input logic [7:0] ad,
                                 input logic bv, input logic [7:0] bd);
        @(negedge clk);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkA(input string tag, input logic rdy, input logic busy,
                          input logic [2:0] sl, input logic ot, input logic strb,
                          input logic lst);
        checkOutput({tag, "_ready"},  int'(a_ready),  int'(rdy));
        checkOutput({tag, "_busy"},   int'(a_busy),   int'(busy));
        checkOutput({tag, "_sl"},     int'(a_sl),     int'(sl));
        checkOutput({tag, "_ot"},     int'(a_ot),     int'(ot));
        checkOutput({tag, "_strobe"}, int'(a_strobe), int'(strb));
        checkOutput({tag, "_last"},   int'(a_last),   int'(lst));
    endtask

    initial begin
        int strobe_cnt;
        int last_cyc;
        logic bits_3c [8];
        logic bits_81 [8];
        bits_3c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bits_81 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // LSB-first 8'hA5 frame, then back-to-back 8'hFF / 8'h00 on instance A.
        vecs.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'hA5));
        vecs.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'hFF));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 8'h00));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00));

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, 1'b0, 8'h00);
            checkA($sformatf("tbl%0d", i), vecs[i].rdy, vecs[i].busy, vecs[i].sl,
                   vecs[i].ot, vecs[i].strb, vecs[i].lst);
            checkOutput($sformatf("tbl%0d_it", i), int'(a_it), int'(vecs[i].it));
        end

        // Instance B: DIV=3, MSB-first, byte 8'h3C.
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
        checkOutput("b_idle_ready", int'(b_ready), 1);
        checkOutput("b_idle_sl", int'(b_sl), 7);
        strobe_cnt = 0;
        last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
                checkOutput($sformatf("b_sl_%0d_%0d", k, c), int'(b_sl), 7 - k);
                checkOutput($sformatf("b_ot_%0d_%0d", k, c), int'(b_ot), int'(bits_3c[k]));
                checkOutput($sformatf("b_strobe_%0d_%0d", k, c), int'(b_strobe), (c == 2) ? 1 : 0);
                checkOutput($sformatf("b_busy_%0d_%0d", k, c), int'(b_busy), 1);
                checkOutput($sformatf("b_ready_%0d_%0d", k, c), int'(b_ready),
                            (k == 7 && c == 2) ? 1 : 0);
                if (b_strobe) strobe_cnt++;
                if (b_last) last_cyc = k * 3 + c + 1;
            end
        end
        checkOutput("b_strobe_count", strobe_cnt, 8);
        checkOutput("b_last_cycle", last_cyc, 24);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("b_end_busy", int'(b_busy), 0);
        checkOutput("b_end_sl", int'(b_sl), 7);

        // Stall: 8'h12 offered mid-frame must be ignored, then taken in IDLE.
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus((k == 3) ? 1'b1 : 1'b0, (k == 3) ? 8'h12 : 8'h00, 1'b0, 8'h00);
            if (k == 3) checkOutput("stall_ready", int'(a_ready), 0);
            checkOutput($sformatf("stall_it_%0d", k), int'(a_it), 8'h5A);
        end
        applyStimulus(1'b1, 8'h12, 1'b0, 8'h00);
        checkOutput("stall_idle_busy", int'(a_busy), 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("stall_loaded_it", int'(a_it), 8'h12);
        checkOutput("stall_loaded_busy", int'(a_busy), 1);
        checkOutput("stall_loaded_sl", int'(a_sl), 0);
        repeat (8) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("stall_done_busy", int'(a_busy), 0);

        // Abort: reset in bit 4 of 8'hC3 clears everything without a clock edge.
        applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00);
        for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("abort_pre_sl", int'(a_sl), 4);
        checkOutput("abort_pre_busy", int'(a_busy), 1);
        #1 rst = 1'b1;
        #1;
        checkA("abort", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_it", int'(a_it), 8'h00);
        checkOutput("abort_b_it", int'(b_it), 8'h00);
        checkOutput("abort_b_sl", int'(b_sl), 7);
        checkOutput("abort_b_ready", int'(b_ready), 1);
        @(posedge clk);
        #1;
        checkOutput("abort_hold_last", int'(a_last), 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean reload after the abort.
        applyStimulus(1'b1, 8'h81, 1'b0, 8'h00);
        checkOutput("reload_ready", int'(a_ready), 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
            checkA($sformatf("reload%0d", k), (k == 8) ? 1'b1 : 1'b0, 1'b1, 3'(k - 1),
                   bits_81[k - 1], 1'b1, (k == 8) ? 1'b1 : 1'b0);
        end
        checkOutput("reload_it", int'(a_it), 8'h81);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("reload_end_busy", int'(a_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
